mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage in the 5-stage in-order core.
- Registers the execute-to-memory bus and aligns and extends load data from the synchronous data SRAM.
- Selects the final result from ALU, multiplier, divider or load, and drives the writeback bus and the decode-stage forwarding bus.
- Hold registers keep the SRAM read data and multiplier result valid across writeback back-pressure.

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage.sv | 103 ++++++++++
 tb/tb_mem_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute->memory->writeback handshake, payload buses, SRAM/mul/div operands.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 78,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_forward_bus;
  logic                       ms_to_ds_valid;
  logic [31:0]                data_sram_rdata;
  logic [63:0]                mul_result;
  logic [31:0]                div_quotient;
  logic [31:0]                div_remainder;
  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata, mul_result, div_quotient, div_remainder,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus, ms_to_ds_valid
  );
  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata, mul_result, div_quotient, div_remainder,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus, ms_to_ds_valid
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; load align/extend, result select, writeback and forward buses.
// Defining MS_STALL_CNT_EN adds the ms_stall_cnt back-pressure cycle counter output.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 78,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
`ifdef MS_STALL_CNT_EN
  ,
  output logic [31:0] ms_stall_cnt
`endif
);
  logic                       ms_valid;
  logic                       first_cyc;
  logic                       rdata_hold_v;
  logic                       mul_hold_v;
  logic                       accept;
  logic                       leave;
  logic                       capture;
  logic [ES_TO_MS_BUS_WD-1:0] es_r;
  logic [31:0]                div_q_r;
  logic [31:0]                div_r_r;
  logic [31:0]                rdata_hold;
  logic [63:0]                mul_hold;
  logic                       sign_ext;
  logic [1:0]                 mem_size;
  logic [3:0]                 mul_div_op;
  logic                       load_op;
  logic                       gr_we;
  logic [4:0]                 dest;
  logic [31:0]                alu_result;
  logic [31:0]                pc;
  logic [31:0]                rdata_e;
  logic [63:0]                mul_e;
  logic [7:0]                 ld_b;
  logic [15:0]                ld_h;
  logic [31:0]                load_data;
  logic [31:0]                final_result;
  logic                       forward_enable;
  assign {sign_ext, mem_size, mul_div_op, load_op, gr_we, dest, alu_result, pc} = es_r;
  assign bus.ms_allowin     = !ms_valid | bus.ws_allowin;
  assign bus.ms_to_ws_valid = ms_valid;
  assign bus.ms_to_ds_valid = ms_valid;
  assign accept  = bus.ms_allowin & bus.es_to_ms_valid;
  assign leave   = ms_valid & bus.ws_allowin;
  // SRAM data and multiplier product are only valid in the first cycle, so freeze them if stalled then
  assign capture = first_cyc & !bus.ws_allowin;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid     <= 1'b0;
      first_cyc    <= 1'b0;
      rdata_hold_v <= 1'b0;
      mul_hold_v   <= 1'b0;
    end else begin
      if (bus.ms_allowin) ms_valid <= bus.es_to_ms_valid;
      first_cyc <= accept;
      if (leave) begin
        rdata_hold_v <= 1'b0;
        mul_hold_v   <= 1'b0;
      end else if (capture) begin
        rdata_hold_v <= 1'b1;
        mul_hold_v   <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      es_r    <= bus.es_to_ms_bus;
      div_q_r <= bus.div_quotient;
      div_r_r <= bus.div_remainder;
    end
    if (capture) begin
      rdata_hold <= bus.data_sram_rdata;
      mul_hold   <= bus.mul_result;
    end
  end
`ifdef MS_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) ms_stall_cnt <= 32'd0;
    else if (ms_valid & !bus.ws_allowin) ms_stall_cnt <= ms_stall_cnt + 32'd1;
  end
`endif
  assign rdata_e = rdata_hold_v ? rdata_hold : bus.data_sram_rdata;
  assign mul_e   = mul_hold_v ? mul_hold : bus.mul_result;
  assign ld_b    = rdata_e[{alu_result[1:0], 3'b000} +: 8];
  assign ld_h    = alu_result[1] ? rdata_e[31:16] : rdata_e[15:0];
  always_comb begin
    load_data = mem_size == 2'b01 ? {{24{sign_ext & ld_b[7]}}, ld_b} :
                mem_size == 2'b10 ? {{16{sign_ext & ld_h[15]}}, ld_h} :
                mem_size == 2'b00 ? rdata_e : 32'd0;
    final_result = load_op       ? load_data :
                   mul_div_op[0] ? mul_e[31:0] :
                   mul_div_op[1] ? mul_e[63:32] :
                   mul_div_op[2] ? div_q_r :
                   mul_div_op[3] ? div_r_r : alu_result;
  end
  assign forward_enable           = ms_valid & gr_we & (dest != 5'd0);
  assign bus.ms_to_ws_bus         = {gr_we, dest, final_result, pc};
  assign bus.ms_to_ds_forward_bus = {1'b0, forward_enable, dest, final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage; a monitor checks every writeback transfer against a queue.
module tb_mem_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mem_stage_if bus_if ();
`ifdef MS_STALL_CNT_EN
  logic [31:0] ms_stall_cnt;
`endif
  mem_stage dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus_if)
`ifdef MS_STALL_CNT_EN
    ,
    .ms_stall_cnt(ms_stall_cnt)
`endif
  );
  int total = 0;
  int bad = 0;
  logic [69:0] exp_q[$];
  logic [69:0] exp_e;
  logic [38:0] fwd;

  function automatic logic [77:0] mk(input logic sx, input logic [1:0] sz, input logic [3:0] md,
                                     input logic ld, input logic we, input logic [4:0] d,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {sx, sz, md, ld, we, d, alu, pc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus_if.ms_to_ws_valid && bus_if.ws_allowin) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL ws_xfer: unexpected transfer got %h", bus_if.ms_to_ws_bus);
      end else begin
        exp_e = exp_q.pop_front();
        if (bus_if.ms_to_ws_bus !== exp_e) begin
          bad++;
          $display("FAIL ws_bus: got %h want %h", bus_if.ms_to_ws_bus, exp_e);
        end
      end
    end
  end

  task automatic run(input logic [77:0] b, input logic [31:0] rd, input logic [63:0] mr,
                     input logic [31:0] dq, input logic [31:0] dr, input int stall_n,
                     input logic [31:0] res);
    exp_q.push_back({b[69], b[68:64], res, b[31:0]});
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = b;
    bus_if.div_quotient   = dq;
    bus_if.div_remainder  = dr;
    bus_if.ws_allowin     = (stall_n == 0);
    @(posedge clk); #1;
    bus_if.es_to_ms_valid  = 1'b0;
    bus_if.div_quotient    = 32'd0;
    bus_if.div_remainder   = 32'd0;
    bus_if.data_sram_rdata = rd;
    bus_if.mul_result      = mr;
    @(negedge clk);
    fwd = bus_if.ms_to_ds_forward_bus;
    for (int i = 0; i < stall_n; i++) begin
      chk("allowin_stall", {31'd0, bus_if.ms_allowin}, 32'd0);
      @(posedge clk); #1;
      bus_if.data_sram_rdata = 32'd0;
      bus_if.mul_result      = 64'd0;
      if (i == stall_n - 1) bus_if.ws_allowin = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus_if.ws_allowin = 1'b1;
  endtask

  initial begin
    bus_if.ws_allowin      = 1'b1;
    bus_if.es_to_ms_valid  = 1'b0;
    bus_if.es_to_ms_bus    = '0;
    bus_if.data_sram_rdata = '0;
    bus_if.mul_result      = '0;
    bus_if.div_quotient    = '0;
    bus_if.div_remainder   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ws_valid", {31'd0, bus_if.ms_to_ws_valid}, 32'd0);
    chk("rst_ds_valid", {31'd0, bus_if.ms_to_ds_valid}, 32'd0);
    chk("rst_allowin", {31'd0, bus_if.ms_allowin}, 32'd1);
    chk("rst_fwd_en", {31'd0, bus_if.ms_to_ds_forward_bus[37]}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run(mk(1, 2'b01, 4'b0000, 1, 1, 5'd4, 32'h1003, 32'h100), 32'h80FF_1234, 64'd0, 0, 0, 0, 32'hFFFF_FF80);
    @(negedge clk);
    chk("byte_one_cycle", {31'd0, bus_if.ms_to_ws_valid}, 32'd0);
    @(posedge clk); #1;
    run(mk(0, 2'b01, 4'b0000, 1, 1, 5'd4, 32'h1001, 32'h104), 32'h80FF_1234, 64'd0, 0, 0, 0, 32'h0000_0012);
    run(mk(0, 2'b10, 4'b0000, 1, 1, 5'd6, 32'h2002, 32'h108), 32'h8001_7FFF, 64'd0, 0, 0, 0, 32'h0000_8001);
    run(mk(1, 2'b10, 4'b0000, 1, 1, 5'd6, 32'h2002, 32'h10C), 32'h8001_7FFF, 64'd0, 0, 0, 0, 32'hFFFF_8001);
    run(mk(1, 2'b11, 4'b0000, 1, 1, 5'd6, 32'h2000, 32'h110), 32'hFFFF_FFFF, 64'd0, 0, 0, 0, 32'd0);
    run(mk(0, 2'b00, 4'b0001, 1, 1, 5'd7, 32'h3000, 32'h114), 32'hDEAD_BEEF, 64'h5, 0, 0, 3, 32'hDEAD_BEEF);
`ifdef MS_STALL_CNT_EN
    chk("stall_cnt3", ms_stall_cnt, 32'd3);
`endif
    run(mk(0, 2'b00, 4'b0001, 0, 1, 5'd8, 32'h55, 32'h118), 32'd0, 64'h0000_000A_0000_000B, 0, 0, 1, 32'h0000_000B);
`ifdef MS_STALL_CNT_EN
    chk("stall_cnt4", ms_stall_cnt, 32'd4);
`endif
    run(mk(0, 2'b00, 4'b0010, 0, 1, 5'd9, 32'h55, 32'h11C), 32'd0, 64'h0000_0001_0000_0002, 0, 0, 0, 32'h0000_0001);
    run(mk(0, 2'b00, 4'b1000, 0, 1, 5'd10, 32'h55, 32'h120), 32'd0, 64'd0, 32'd3, 32'd7, 1, 32'd7);
    run(mk(0, 2'b00, 4'b0100, 0, 1, 5'd11, 32'h55, 32'h124), 32'd0, 64'd0, 32'd9, 32'd7, 0, 32'd9);
    run(mk(0, 2'b00, 4'b0000, 0, 1, 5'd0, 32'h11, 32'h128), 32'd0, 64'd0, 0, 0, 0, 32'h11);
    chk("fwd_en_dest0", {31'd0, fwd[37]}, 32'd0);
    run(mk(0, 2'b00, 4'b0000, 0, 1, 5'd5, 32'h22, 32'h12C), 32'd0, 64'd0, 0, 0, 0, 32'h22);
    chk("fwd_en_dest5", {31'd0, fwd[37]}, 32'd1);
    chk("fwd_dest", {27'd0, fwd[36:32]}, 32'd5);
    chk("fwd_stall", {31'd0, fwd[38]}, 32'd0);
    chk("fwd_result", fwd[31:0], 32'h22);
    run(mk(0, 2'b00, 4'b0000, 0, 0, 5'd5, 32'h33, 32'h130), 32'd0, 64'd0, 0, 0, 0, 32'h33);
    chk("fwd_en_nowe", {31'd0, fwd[37]}, 32'd0);
    bus_if.es_to_ms_valid = 1'b1;
    bus_if.es_to_ms_bus   = mk(0, 2'b00, 4'b0000, 1, 1, 5'd3, 32'h4000, 32'h134);
    bus_if.ws_allowin     = 1'b0;
    @(posedge clk); #1;
    bus_if.es_to_ms_valid  = 1'b0;
    bus_if.data_sram_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_if.data_sram_rdata = 32'd0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_ws_valid", {31'd0, bus_if.ms_to_ws_valid}, 32'd0);
    chk("midrst_allowin", {31'd0, bus_if.ms_allowin}, 32'd1);
    chk("midrst_fwd_en", {31'd0, bus_if.ms_to_ds_forward_bus[37]}, 32'd0);
`ifdef MS_STALL_CNT_EN
    chk("midrst_cnt", ms_stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    run(mk(0, 2'b00, 4'b0000, 1, 1, 5'd3, 32'h4000, 32'h138), 32'h1234_5678, 64'd0, 0, 0, 0, 32'h1234_5678);
    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
